// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC sample sequencer.
package agc_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } agc_seq_state_t;

    // Configuration bus geometry and register map.
    localparam int CFG_ADDR_W = 2;
    localparam int CFG_DATA_W = 16;

    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_FILTER = 2'd0;
    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_ERROR  = 2'd1;
    localparam logic [CFG_ADDR_W-1:0] CFG_ADDR_R      = 2'd2;

endpackage

// File: rtl/agc_sequencer_if.sv
// Bundle of the upstream stream, config port, AGC core port and downstream
// stream seen by the sequencer. "slave" is the sequencer side, "master" the
// surrounding system.
interface agc_sequencer_if
    import agc_pkg::*;
#(
    parameter int W_IN        = 16,
    parameter int W_IN_MODULE = 26,
    parameter int FILTERWIDTH = 13,
    parameter int RWIDTH      = 8
);
    // Upstream sample stream
    logic                          in_valid;
    logic                          in_ready;
    logic signed [W_IN-1:0]        in_I;
    logic signed [W_IN-1:0]        in_Q;
    // Configuration writes
    logic                          cfg_wr;
    logic [CFG_ADDR_W-1:0]         cfg_addr;
    logic [CFG_DATA_W-1:0]         cfg_data;
    // AGC core side
    logic signed [W_IN-1:0]        agc_dataI;
    logic signed [W_IN-1:0]        agc_dataQ;
    logic                          agc_valid;
    logic [FILTERWIDTH-1:0]        agc_filter;
    logic [FILTERWIDTH-1:0]        agc_error;
    logic [RWIDTH-1:0]             agc_r;
    logic                          agc_vout;
    logic signed [W_IN_MODULE-1:0] agc_outI;
    logic signed [W_IN_MODULE-1:0] agc_outQ;
    // Downstream result stream
    logic                          out_valid;
    logic                          out_ready;
    logic signed [W_IN_MODULE-1:0] out_I;
    logic signed [W_IN_MODULE-1:0] out_Q;
    // Status
    logic                          cfg_pending;
    logic                          busy;
    logic                          err_timeout;
    logic                          err_spurious;

    modport slave (
        input  in_valid, in_I, in_Q, cfg_wr, cfg_addr, cfg_data,
               agc_vout, agc_outI, agc_outQ, out_ready,
        output in_ready, agc_dataI, agc_dataQ, agc_valid, agc_filter,
               agc_error, agc_r, out_valid, out_I, out_Q, cfg_pending,
               busy, err_timeout, err_spurious
    );

    modport master (
        output in_valid, in_I, in_Q, cfg_wr, cfg_addr, cfg_data,
               agc_vout, agc_outI, agc_outQ, out_ready,
        input  in_ready, agc_dataI, agc_dataQ, agc_valid, agc_filter,
               agc_error, agc_r, out_valid, out_I, out_Q, cfg_pending,
               busy, err_timeout, err_spurious
    );

endinterface

// File: rtl/agc_cfg_regs.sv
// Shadow/active coefficient bank. Writes land in the shadow copy; the active
// copy driving the AGC only moves at a sample start, so coefficients stay
// frozen while a sample is in flight.
module agc_cfg_regs
    import agc_pkg::*;
#(
    parameter int FILTERWIDTH = 13,
    parameter int RWIDTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr,
    input  logic [CFG_ADDR_W-1:0]  cfg_addr,
    input  logic [CFG_DATA_W-1:0]  cfg_data,
    input  logic                   sample_start,
    output logic [FILTERWIDTH-1:0] act_filter,
    output logic [FILTERWIDTH-1:0] act_error,
    output logic [RWIDTH-1:0]      act_r,
    output logic                   cfg_pending
);

    logic [FILTERWIDTH-1:0] shd_filter_q, shd_filter_d;
    logic [FILTERWIDTH-1:0] shd_error_q,  shd_error_d;
    logic [RWIDTH-1:0]      shd_r_q,      shd_r_d;
    logic [FILTERWIDTH-1:0] act_filter_q, act_filter_d;
    logic [FILTERWIDTH-1:0] act_error_q,  act_error_d;
    logic [RWIDTH-1:0]      act_r_q,      act_r_d;
    logic                   pending_q,    pending_d;
    logic                   apply;

    // Upper data bits are don't-care for the narrower registers.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data;

    // Apply uses the pre-write shadow; a write in the same cycle keeps pending set.
    always_comb begin
        shd_filter_d = shd_filter_q;
        shd_error_d  = shd_error_q;
        shd_r_d      = shd_r_q;
        act_filter_d = act_filter_q;
        act_error_d  = act_error_q;
        act_r_d      = act_r_q;
        pending_d    = pending_q;
        apply        = sample_start && pending_q;

        if (apply) begin
            act_filter_d = shd_filter_q;
            act_error_d  = shd_error_q;
            act_r_d      = shd_r_q;
            pending_d    = 1'b0;
        end

        if (cfg_wr) begin
            case (cfg_addr)
                CFG_ADDR_FILTER: begin
                    shd_filter_d = cfg_data[FILTERWIDTH-1:0];
                    pending_d    = 1'b1;
                end
                CFG_ADDR_ERROR: begin
                    shd_error_d = cfg_data[FILTERWIDTH-1:0];
                    pending_d   = 1'b1;
                end
                CFG_ADDR_R: begin
                    shd_r_d   = cfg_data[RWIDTH-1:0];
                    pending_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Register bank with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_filter_q <= '0;
            shd_error_q  <= '0;
            shd_r_q      <= '0;
            act_filter_q <= '0;
            act_error_q  <= '0;
            act_r_q      <= '0;
            pending_q    <= 1'b0;
        end else begin
            shd_filter_q <= shd_filter_d;
            shd_error_q  <= shd_error_d;
            shd_r_q      <= shd_r_d;
            act_filter_q <= act_filter_d;
            act_error_q  <= act_error_d;
            act_r_q      <= act_r_d;
            pending_q    <= pending_d;
        end
    end

    assign act_filter  = act_filter_q;
    assign act_error   = act_error_q;
    assign act_r       = act_r_q;
    assign cfg_pending = pending_q;

endmodule

// File: rtl/agc_sequencer.sv
// Sample scheduler in front of the AGC core: one strobe per accepted sample,
// spaced at least SAMPLE_PERIOD clocks, result held until downstream takes it.
module agc_sequencer
    import agc_pkg::*;
#(
    parameter int W_IN          = 16,
    parameter int W_IN_MODULE   = 26,
    parameter int FILTERWIDTH   = 13,
    parameter int RWIDTH        = 8,
    parameter int SAMPLE_PERIOD = 40,
    parameter int TIMEOUT       = 64
) (
    input logic            clk,
    input logic            rst_n,
    agc_sequencer_if.slave bus
);

    // The period counter is 0 during ISSUE and counts every clock after it,
    // saturating well above both limits.
    localparam int CNT_W = $clog2(SAMPLE_PERIOD + TIMEOUT + 2);
    // Leaving GAP when the counter steps to SAMPLE_PERIOD-1 puts the IDLE
    // accept cycle exactly SAMPLE_PERIOD clocks after the previous strobe.
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SAMPLE_PERIOD - 2);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT);

    agc_seq_state_t                state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic signed [W_IN-1:0]        idat_q, idat_d;
    logic signed [W_IN-1:0]        qdat_q, qdat_d;
    logic signed [W_IN_MODULE-1:0] ires_q, ires_d;
    logic signed [W_IN_MODULE-1:0] qres_q, qres_d;
    logic                          agc_valid_q, agc_valid_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;
    logic                          err_timeout_q, err_timeout_d;
    logic                          err_spurious_q, err_spurious_d;
    logic                          in_ready;
    logic                          accept;
    logic [FILTERWIDTH-1:0]        act_filter, act_error;
    logic [RWIDTH-1:0]             act_r;
    logic                          cfg_pending;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    agc_cfg_regs #(
        .FILTERWIDTH (FILTERWIDTH),
        .RWIDTH      (RWIDTH)
    ) u_cfg (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wr       (bus.cfg_wr),
        .cfg_addr     (bus.cfg_addr),
        .cfg_data     (bus.cfg_data),
        .sample_start (accept),
        .act_filter   (act_filter),
        .act_error    (act_error),
        .act_r        (act_r),
        .cfg_pending  (cfg_pending)
    );

    // Next-state, sample/result capture and sticky error flags.
    always_comb begin
        state_d        = state_q;
        cnt_d          = sat_inc(cnt_q);
        idat_d         = idat_q;
        qdat_d         = qdat_q;
        ires_d         = ires_q;
        qres_d         = qres_q;
        out_valid_d    = out_valid_q && !bus.out_ready;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idat_d  = bus.in_I;
                    qdat_d  = bus.in_Q;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.agc_vout) begin
                    ires_d      = bus.agc_outI;
                    qres_d      = bus.agc_outQ;
                    out_valid_d = 1'b1;
                    state_d     = GAP;
                end else if (cnt_q == WAIT_LIMIT) begin
                    err_timeout_d = 1'b1;
                    state_d       = GAP;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.agc_vout && (state_q != WAIT)) err_spurious_d = 1'b1;

        agc_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    // All control, data and status registers; reset aborts any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idat_q         <= '0;
            qdat_q         <= '0;
            ires_q         <= '0;
            qres_q         <= '0;
            agc_valid_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idat_q         <= idat_d;
            qdat_q         <= qdat_d;
            ires_q         <= ires_d;
            qres_q         <= qres_d;
            agc_valid_q    <= agc_valid_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.agc_dataI    = idat_q;
    assign bus.agc_dataQ    = qdat_q;
    assign bus.agc_valid    = agc_valid_q;
    assign bus.agc_filter   = act_filter;
    assign bus.agc_error    = act_error;
    assign bus.agc_r        = act_r;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_I        = ires_q;
    assign bus.out_Q        = qres_q;
    assign bus.cfg_pending  = cfg_pending;
    assign bus.busy         = busy_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_spurious = err_spurious_q;

endmodule

// File: tb/tb_agc_sequencer.sv
// Directed bench for agc_sequencer with default parameters
// (SAMPLE_PERIOD=40, TIMEOUT=64).
module tb_agc_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t_prev = 0;
    logic saw;

    logic signed [15:0] smp_i [3] = '{16'sd10, 16'sd20, 16'sd30};
    logic signed [25:0] res_i [3] = '{26'sd1010, 26'sd1020, 26'sd1030};
    logic signed [25:0] res_q [3] = '{-26'sd11, -26'sd22, -26'sd33};

    agc_sequencer_if bus ();

    agc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        bus.cfg_wr   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        tick();
        bus.cfg_wr   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 200), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_I      = '0;
        bus.in_Q      = '0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.agc_vout  = 1'b0;
        bus.agc_outI  = '0;
        bus.agc_outQ  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_agc_valid", 64'(bus.agc_valid), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_pending", 64'(bus.cfg_pending), 64'd0);
        chk("rst_filter", 64'(bus.agc_filter), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Test 1: configure then single sample
        cfg_write(2'd0, 16'h0155);
        cfg_write(2'd1, 16'h0020);
        cfg_write(2'd2, 16'h0040);
        chk("t1_pending_before", 64'(bus.cfg_pending), 64'd1);
        chk("t1_filter_before", 64'(bus.agc_filter), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_I     = 16'sd100;
        bus.in_Q     = -16'sd100;
        chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
        tick();                                  // accept edge
        bus.in_valid = 1'b0;
        t_prev = cyc;
        chk("t1_strobe", 64'(bus.agc_valid), 64'd1);
        chk("t1_dataI", 64'(bus.agc_dataI), 64'(16'sd100));
        chk("t1_dataQ", 64'(bus.agc_dataQ), 64'(-16'sd100));
        chk("t1_filter", 64'(bus.agc_filter), 64'h155);
        chk("t1_error", 64'(bus.agc_error), 64'h20);
        chk("t1_r", 64'(bus.agc_r), 64'h40);
        chk("t1_pending_after", 64'(bus.cfg_pending), 64'd0);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        tick();                                  // now WAIT
        chk("t1_strobe_single", 64'(bus.agc_valid), 64'd0);
        bus.agc_vout = 1'b1;
        bus.agc_outI = 26'sd1234;
        bus.agc_outQ = -26'sd5;
        tick();
        bus.agc_vout = 1'b0;
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_out_I", 64'(bus.out_I), 64'(26'sd1234));
        chk("t1_out_Q", 64'(bus.out_Q), 64'(-26'sd5));
        tick();
        chk("t1_out_taken", 64'(bus.out_valid), 64'd0);
        repeat (35) tick();                      // 38 edges after accept
        chk("t1_gap_not_ready", 64'(bus.in_ready), 64'd0);
        tick();                                  // 39 edges after accept
        chk("t1_gap_ready", 64'(bus.in_ready), 64'd1);
        chk("t1_idle_busy", 64'(bus.busy), 64'd0);

        // Test 2: three back-to-back samples, AGC answers 12 clocks after strobe
        for (int k = 0; k < 3; k++) begin
            wait_ready("t2_ready_wait");
            bus.in_valid = 1'b1;
            bus.in_I     = smp_i[k];
            bus.in_Q     = -smp_i[k];
            tick();
            bus.in_valid = 1'b0;
            chk("t2_strobe", 64'(bus.agc_valid), 64'd1);
            chk("t2_spacing", 64'(cyc - t_prev), 64'd40);
            chk("t2_dataI", 64'(bus.agc_dataI), 64'(smp_i[k]));
            t_prev = cyc;
            repeat (11) tick();
            bus.agc_vout = 1'b1;
            bus.agc_outI = res_i[k];
            bus.agc_outQ = res_q[k];
            tick();
            bus.agc_vout = 1'b0;
            chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
            chk("t2_out_I", 64'(bus.out_I), 64'(res_i[k]));
            chk("t2_out_Q", 64'(bus.out_Q), 64'(res_q[k]));
        end

        // Test 3/4: R write during WAIT, AGC never answers
        wait_ready("t3_ready_wait");
        bus.in_valid = 1'b1;
        bus.in_I     = 16'sd7;
        bus.in_Q     = 16'sd7;
        tick();
        bus.in_valid = 1'b0;
        chk("t3_strobe", 64'(bus.agc_valid), 64'd1);
        tick();                                  // WAIT
        cfg_write(2'd2, 16'h0010);
        cfg_write(2'd3, 16'h0AAA);               // address 3 ignored
        chk("t3_r_held", 64'(bus.agc_r), 64'h40);
        chk("t3_pending", 64'(bus.cfg_pending), 64'd1);
        repeat (61) tick();                      // 64 edges after accept
        chk("t4_no_timeout_yet", 64'(bus.err_timeout), 64'd0);
        chk("t4_not_ready", 64'(bus.in_ready), 64'd0);
        tick();                                  // 65 edges after accept
        chk("t4_timeout", 64'(bus.err_timeout), 64'd1);
        chk("t4_busy_gap", 64'(bus.busy), 64'd1);
        chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("t4_ready_back", 64'(bus.in_ready), 64'd1);

        // Accept with a simultaneous filter write: pre-write shadow applies
        bus.in_valid = 1'b1;
        bus.in_I     = -16'sd1;
        bus.in_Q     = 16'sd2;
        bus.cfg_wr   = 1'b1;
        bus.cfg_addr = 2'd0;
        bus.cfg_data = 16'h0033;
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_wr   = 1'b0;
        chk("t3_strobe2", 64'(bus.agc_valid), 64'd1);
        chk("t3_r_applied", 64'(bus.agc_r), 64'h10);
        chk("t3_filter_prewrite", 64'(bus.agc_filter), 64'h155);
        chk("t3_error_kept", 64'(bus.agc_error), 64'h20);
        chk("t3_pending_stays", 64'(bus.cfg_pending), 64'd1);
        chk("t3_dataI", 64'(bus.agc_dataI), 64'(-16'sd1));

        // Test 5: downstream stall holds result and blocks the next sample
        bus.out_ready = 1'b0;
        tick();                                  // WAIT
        bus.agc_vout = 1'b1;
        bus.agc_outI = 26'sd555;
        bus.agc_outQ = -26'sd555;
        tick();
        bus.agc_vout = 1'b0;
        chk("t5_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_out_I", 64'(bus.out_I), 64'(26'sd555));
        bus.in_valid = 1'b1;
        bus.in_I     = 16'sd42;
        bus.in_Q     = 16'sd0;
        saw = 1'b0;
        repeat (60) begin
            tick();
            if (bus.agc_valid) saw = 1'b1;
        end
        chk("t5_no_strobe", 64'(saw), 64'd0);
        chk("t5_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("t5_held_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_held_I", 64'(bus.out_I), 64'(26'sd555));
        chk("t5_held_Q", 64'(bus.out_Q), 64'(-26'sd555));
        chk("t5_idle", 64'(bus.busy), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("t5_in_ready_comb", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("t5_strobe", 64'(bus.agc_valid), 64'd1);
        chk("t5_out_cleared", 64'(bus.out_valid), 64'd0);
        chk("t5_filter_new", 64'(bus.agc_filter), 64'h033);
        chk("t5_pending_clear", 64'(bus.cfg_pending), 64'd0);
        chk("t5_dataI", 64'(bus.agc_dataI), 64'(16'sd42));

        // Test 6: spurious Valid_Out in IDLE, then reset mid-WAIT
        tick();                                  // WAIT
        bus.agc_vout = 1'b1;
        bus.agc_outI = 26'sd77;
        bus.agc_outQ = 26'sd0;
        tick();
        bus.agc_vout = 1'b0;
        chk("t6_out_I", 64'(bus.out_I), 64'(26'sd77));
        wait_ready("t6_ready_wait");
        chk("t6_no_spurious", 64'(bus.err_spurious), 64'd0);
        bus.agc_vout = 1'b1;
        bus.agc_outI = 26'sd999;
        tick();
        bus.agc_vout = 1'b0;
        chk("t6_spurious", 64'(bus.err_spurious), 64'd1);
        chk("t6_ignored_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_ignored_I", 64'(bus.out_I), 64'(26'sd77));
        chk("t6_timeout_sticky", 64'(bus.err_timeout), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_I     = 16'sd9;
        tick();
        bus.in_valid = 1'b0;
        tick();                                  // WAIT
        chk("t6_busy_wait", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_spurious", 64'(bus.err_spurious), 64'd0);
        chk("t6_rst_timeout", 64'(bus.err_timeout), 64'd0);
        chk("t6_rst_filter", 64'(bus.agc_filter), 64'd0);
        chk("t6_rst_r", 64'(bus.agc_r), 64'd0);
        chk("t6_rst_dataI", 64'(bus.agc_dataI), 64'd0);
        chk("t6_rst_out_I", 64'(bus.out_I), 64'd0);
        chk("t6_rst_pending", 64'(bus.cfg_pending), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (bus.agc_valid) saw = 1'b1;
        end
        chk("t6_no_replay", 64'(saw), 64'd0);
        chk("t6_idle_after", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
